bus_master_arbiter: RTL and testbench

- Round-robin arbiter sharing the single CPU-side bus into the clock-domain-crossing fabric among NumMasters requesters (CPU core, DMA, debug port).
- Issues one transaction at a time and holds it until the downstream busy/halt signal has risen and fallen.
- Returns read data and a one-cycle ack to the owning master.
- Inserts an idle-address gap between transactions, so back-to-back accesses to the same address are always seen downstream as new accesses.

---
 rtl/bus_master_arbiter_pkg.sv | 15 +
 rtl/bus_master_arbiter_if.sv | 28 ++
 rtl/bus_master_arbiter_rr_arbiter.sv | 34 +++
 rtl/bus_master_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_master_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_master_arbiter_pkg.sv
// bus_master_arbiter_pkg: shared widths, request record and FSM states for the bus master arbiter.
package bus_master_arbiter_pkg;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, GAP} arb_state_t;
  typedef struct packed {
    logic                 we;
    logic [3:0]           we_ram;
    logic [AddrWidth-1:0] address;
    logic [DataWidth-1:0] data;
  } bus_req_t;
  function automatic int next_idx(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/bus_master_arbiter_if.sv
// bus_master_arbiter_if: requester-side and shared-bus signals; slave is the arbiter view.
interface bus_master_arbiter_if import bus_master_arbiter_pkg::*; #(
  parameter int NumMasters = 2
);
  logic [NumMasters-1:0]                req_i;
  logic [NumMasters-1:0]                we_i;
  logic [NumMasters-1:0][3:0]           we_ram_i;
  logic [NumMasters-1:0][AddrWidth-1:0] address_i;
  logic [NumMasters-1:0][DataWidth-1:0] wdata_i;
  logic [NumMasters-1:0]                ack_o;
  logic [NumMasters-1:0]                err_o;
  logic [DataWidth-1:0]                 rdata_o;
  logic [NumMasters-1:0]                grant_o;
  logic                                 bus_we_o;
  logic [3:0]                           bus_we_ram_o;
  logic [AddrWidth-1:0]                 bus_address_o;
  logic [DataWidth-1:0]                 bus_data_o;
  logic [DataWidth-1:0]                 bus_data_i;
  logic                                 bus_busy_i;
  modport slave (
    input  req_i, we_i, we_ram_i, address_i, wdata_i, bus_data_i, bus_busy_i,
    output ack_o, err_o, rdata_o, grant_o, bus_we_o, bus_we_ram_o, bus_address_o, bus_data_o
  );
  modport master (
    output req_i, we_i, we_ram_i, address_i, wdata_i, bus_data_i, bus_busy_i,
    input  ack_o, err_o, rdata_o, grant_o, bus_we_o, bus_we_ram_o, bus_address_o, bus_data_o
  );
endinterface

// File: rtl/bus_master_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin select from req and pointer; pointer moves past the owner on adv_i.
module rr_arbiter import bus_master_arbiter_pkg::*; #(
  parameter int NumMasters = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NumMasters-1:0] req_i,
  input  logic [NumMasters-1:0] gnt_i,
  input  logic                  adv_i,
  output logic [NumMasters-1:0] sel_o
);
  localparam int PW = $clog2(NumMasters);
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [2*NumMasters-1:0] rot2, sel2;
  logic [NumMasters-1:0]   rot, first;
  int                      gidx;
  // rotate so the pointer sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot2  = {req_i, req_i} >> ptr_q;
    rot   = rot2[NumMasters-1:0];
    first = rot & (~rot + NumMasters'(1));
    sel2  = {first, first} << ptr_q;
    sel_o = sel2[2*NumMasters-1:NumMasters];
  end
  always_comb begin
    gidx = 0;
    for (int k = 0; k < NumMasters; k++) gidx = gnt_i[k] ? k : gidx;
    ptr_d = PW'(next_idx(gidx, NumMasters));
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin owner of the shared CPU bus; BUS_MASTER_ARBITER_TIMEOUT_EN adds a WAIT_DONE abort.
module bus_master_arbiter import bus_master_arbiter_pkg::*; #(
  parameter int                   NumMasters    = 2,
  parameter int                   BusyStartWait = 4,
  parameter int                   TimeoutCycles = 1024,
  parameter logic [AddrWidth-1:0] IdleAddress   = '0
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bus_master_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BusyStartWait + 1);
  arb_state_t                      state_q;
  bus_req_t [NumMasters-1:0]       reqs;
  bus_req_t                        sel_req;
  logic [NumMasters-1:0]           sel, grant_q, ack_q;
  logic [DataWidth-1:0]            rdata_q, bus_data_q;
  logic [AddrWidth-1:0]            bus_addr_q;
  logic                            bus_we_q;
  logic [3:0]                      bus_we_ram_q;
  logic [CW-1:0]                   cnt_q;
  logic                            done, tmo_hit;
  always_comb begin
    sel_req = '0;
    for (int k = 0; k < NumMasters; k++) begin
      reqs[k] = '{we: bus.we_i[k], we_ram: bus.we_ram_i[k], address: bus.address_i[k], data: bus.wdata_i[k]};
      sel_req = sel[k] ? sel_req | reqs[k] : sel_req;
    end
  end
  rr_arbiter #(.NumMasters(NumMasters)) u_rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (bus.req_i),
    .gnt_i   (grant_q),
    .adv_i   (state_q == RESP),
    .sel_o   (sel)
  );
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
  logic [31:0]           tmo_q;
  logic [NumMasters-1:0] err_q;
  assign tmo_hit   = state_q == WAIT_DONE && bus.bus_busy_i && tmo_q == 32'(TimeoutCycles - 1);
  assign bus.err_o = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.err_o = '0;
`endif
  // expiry of the busy-start window means a same-clock target already answered
  assign done = (state_q == WAIT_BUSY && !bus.bus_busy_i && cnt_q == CW'(BusyStartWait - 1)) ||
                (state_q == WAIT_DONE && !bus.bus_busy_i) || tmo_hit;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      bus_we_q     <= 1'b0;
      bus_we_ram_q <= '0;
      bus_addr_q   <= IdleAddress;
      bus_data_q   <= '0;
      cnt_q        <= '0;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
      err_q <= '0;
`endif
      if (done) begin
        state_q    <= RESP;
        ack_q      <= grant_q;
        rdata_q    <= tmo_hit ? '0 : bus.bus_data_i;
        bus_addr_q <= IdleAddress;
        bus_data_q <= '0;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
        err_q      <= tmo_hit ? grant_q : '0;
`endif
      end else begin
        case (state_q)
          IDLE: if (|bus.req_i) begin
            state_q <= ISSUE;
            grant_q <= sel;
            {bus_we_q, bus_we_ram_q, bus_addr_q, bus_data_q} <= sel_req;
          end
          ISSUE: begin
            state_q      <= WAIT_BUSY;
            bus_we_q     <= 1'b0;
            bus_we_ram_q <= '0;
            cnt_q        <= '0;
          end
          WAIT_BUSY: if (bus.bus_busy_i) begin
            state_q <= WAIT_DONE;
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else cnt_q <= cnt_q + CW'(1);
          WAIT_DONE: begin
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
            tmo_q <= tmo_q + 32'd1;
`endif
          end
          RESP: begin
            state_q <= GAP;
            grant_q <= '0;
            rdata_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.ack_o         = ack_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.grant_o       = grant_q;
  assign bus.bus_we_o      = bus_we_q;
  assign bus.bus_we_ram_o  = bus_we_ram_q;
  assign bus.bus_address_o = bus_addr_q;
  assign bus.bus_data_o    = bus_data_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: cycle table for local/crossing transactions plus directed multi-cycle sequences.
module tb_bus_master_arbiter;
  import bus_master_arbiter_pkg::*;
  typedef struct {
    logic rst; logic [1:0] req; logic busy; logic [31:0] bd;
    logic [1:0] g, a; logic [31:0] rd; logic we; logic [3:0] wr; logic [31:0] ad, dt;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[16];
  always #5 clk = ~clk;
  bus_master_arbiter_if #(.NumMasters(2)) bus ();
  bus_master_arbiter #(
    .NumMasters(2), .BusyStartWait(4), .TimeoutCycles(16), .IdleAddress(32'h0)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.req_i = '0;
    bus.bus_busy_i = 1'b0;
    bus.bus_data_i = '0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    bus.req_i = '0;
    bus.bus_busy_i = 1'b0;
    bus.bus_data_i = '0;
    bus.we_i = 2'b10;
    bus.we_ram_i = {4'hF, 4'h0};
    bus.address_i = {32'h200, 32'h10};
    bus.wdata_i = {32'hDEADBEEF, 32'h12345678};
    vt[0]  = '{1'b1, 2'b00, 1'b0, 32'h0,  2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0};
    vt[1]  = '{1'b0, 2'b01, 1'b0, 32'hA5, 2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0};
    for (int i = 2; i <= 6; i++)
      vt[i] = '{1'b0, 2'b01, 1'b0, 32'hA5, 2'b01, 2'b00, 32'h0, 1'b0, 4'h0, 32'h10, 32'h12345678};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h0,  2'b01, 2'b01, 32'hA5, 1'b0, 4'h0, 32'h0,   32'h0};
    vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h0,  2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0};
    vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h0,  2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0};
    vt[10] = '{1'b0, 2'b10, 1'b1, 32'h0,  2'b10, 2'b00, 32'h0,  1'b1, 4'hF, 32'h200, 32'hDEADBEEF};
    vt[11] = '{1'b0, 2'b10, 1'b1, 32'h0,  2'b10, 2'b00, 32'h0,  1'b0, 4'h0, 32'h200, 32'hDEADBEEF};
    vt[12] = '{1'b0, 2'b10, 1'b1, 32'h0,  2'b10, 2'b00, 32'h0,  1'b0, 4'h0, 32'h200, 32'hDEADBEEF};
    vt[13] = '{1'b0, 2'b10, 1'b0, 32'h77, 2'b10, 2'b00, 32'h0,  1'b0, 4'h0, 32'h200, 32'hDEADBEEF};
    vt[14] = '{1'b0, 2'b00, 1'b0, 32'h0,  2'b10, 2'b10, 32'h77, 1'b0, 4'h0, 32'h0,   32'h0};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h0,  2'b00, 2'b00, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0};
    for (int i = 0; i < 16; i++) begin
      tick();
      rst = vt[i].rst;
      bus.req_i = vt[i].req;
      bus.bus_busy_i = vt[i].busy;
      bus.bus_data_i = vt[i].bd;
      @(negedge clk);
      chk($sformatf("row%0d grant", i), bus.grant_o, vt[i].g);
      chk($sformatf("row%0d ack", i), bus.ack_o, vt[i].a);
      chk($sformatf("row%0d err", i), bus.err_o, 2'b00);
      chk($sformatf("row%0d rdata", i), bus.rdata_o, vt[i].rd);
      chk($sformatf("row%0d we", i), bus.bus_we_o, vt[i].we);
      chk($sformatf("row%0d we_ram", i), bus.bus_we_ram_o, vt[i].wr);
      chk($sformatf("row%0d addr", i), bus.bus_address_o, vt[i].ad);
      chk($sformatf("row%0d data", i), bus.bus_data_o, vt[i].dt);
    end
    begin : crossing
      int we_cnt = 0;
      int ack_c = -1;
      do_reset();
      for (int c = 0; c < 32; c++) begin
        tick();
        bus.req_i = (ack_c < 0) ? 2'b10 : 2'b00;
        bus.bus_busy_i = (c >= 2 && c <= 21);
        @(negedge clk);
        if (bus.bus_we_o) we_cnt++;
        if (bus.ack_o != 2'b00 && ack_c < 0) begin
          ack_c = c;
          chk("cross ack owner", bus.ack_o, 2'b10);
        end
      end
      chk("cross we cycles", we_cnt, 1);
      chk("cross ack cycle", ack_c, 23);
    end
    begin : fairness
      int acks = 0;
      int cnt0 = 0;
      int cnt1 = 0;
      do_reset();
      for (int c = 0; c < 120 && acks < 6; c++) begin
        tick();
        bus.req_i = 2'b11;
        @(negedge clk);
        if (bus.ack_o != 2'b00) begin
          chk($sformatf("fair ack%0d", acks), bus.ack_o, (acks % 2 == 0) ? 2'b01 : 2'b10);
          if (bus.ack_o[0]) cnt0++;
          if (bus.ack_o[1]) cnt1++;
          acks++;
        end
      end
      chk("fair total acks", acks, 6);
      chk("fair m0 acks", cnt0, 3);
      chk("fair m1 acks", cnt1, 3);
    end
    begin : same_addr
      int acks = 0;
      int issues = 0;
      int zeros = 0;
      logic [31:0] prev = 32'h0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
        tick();
        bus.req_i = (acks < 2) ? 2'b01 : 2'b00;
        @(negedge clk);
        if (bus.bus_address_o == 32'h10 && prev != 32'h10) begin
          issues++;
          if (issues == 2) chk("same addr idle cycles between", zeros, 3);
          zeros = 0;
        end
        if (bus.bus_address_o == 32'h0 && issues > 0) zeros++;
        if (bus.ack_o != 2'b00) acks++;
        prev = bus.bus_address_o;
      end
      chk("same addr issues", issues, 2);
      chk("same addr acks", acks, 2);
    end
    begin : mid_reset
      int got = 0;
      int acks = 0;
      logic [1:0] g = 2'b00;
      do_reset();
      for (int c = 0; c < 20 && got == 0; c++) begin
        tick();
        bus.req_i = 2'b01;
        @(negedge clk);
        if (bus.ack_o != 2'b00) got = 1;
      end
      chk("rst m0 first ack", got, 1);
      tick();
      bus.req_i = 2'b10;
      bus.bus_busy_i = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      @(negedge clk);
      chk("rst pre grant", bus.grant_o, 2'b10);
      chk("rst pre addr", bus.bus_address_o, 32'h200);
      tick();
      rst = 1'b1;
      bus.req_i = 2'b00;
      tick();
      rst = 1'b0;
      bus.bus_busy_i = 1'b0;
      @(negedge clk);
      chk("rst grant", bus.grant_o, 2'b00);
      chk("rst ack", bus.ack_o, 2'b00);
      chk("rst err", bus.err_o, 2'b00);
      chk("rst rdata", bus.rdata_o, 32'h0);
      chk("rst we", bus.bus_we_o, 1'b0);
      chk("rst addr", bus.bus_address_o, 32'h0);
      chk("rst data", bus.bus_data_o, 32'h0);
      for (int c = 0; c < 10 && g == 2'b00; c++) begin
        tick();
        bus.req_i = 2'b11;
        @(negedge clk);
        g = bus.grant_o;
        if (bus.ack_o != 2'b00) acks++;
      end
      chk("rst next grant", g, 2'b01);
      chk("rst no stray ack", acks, 0);
    end
`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
    begin : timeout
      int ack_c = -1;
      do_reset();
      for (int c = 0; c < 40; c++) begin
        tick();
        bus.req_i = (ack_c < 0) ? 2'b01 : 2'b00;
        bus.bus_busy_i = 1'b1;
        bus.bus_data_i = 32'hFF;
        @(negedge clk);
        if (bus.ack_o != 2'b00 && ack_c < 0) begin
          ack_c = c;
          chk("tmo ack", bus.ack_o, 2'b01);
          chk("tmo err", bus.err_o, 2'b01);
          chk("tmo rdata", bus.rdata_o, 32'h0);
        end
      end
      chk("tmo ack cycle", ack_c, 19);
    end
`else
    begin : no_timeout
      int acks = 0;
      do_reset();
      for (int c = 0; c < 40; c++) begin
        tick();
        bus.req_i = 2'b01;
        bus.bus_busy_i = 1'b1;
        @(negedge clk);
        if (bus.ack_o != 2'b00 || bus.err_o != 2'b00) acks++;
      end
      chk("no timeout ack", acks, 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
